// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Samples a time-multiplexed 4-digit 7-segment bus and rebuilds the displayed
// 16-bit hex value. Each (an, seg) pair must hold for STABLE_CYC sampled
// cycles before it is captured into its digit slot. A frame is published once
// all four digits have been captured since the previous frame.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   seg[7:0]    segment lines, seg[0]=a .. seg[6]=g, seg[7]=dp (active-high)
//   an[3:0]     one-hot digit select, an[i] selects digit i
//   value[15:0] last complete frame, digit i in value[4i+3:4i]
//   dp[3:0]     decimal points of last frame
//   err_mask    digit i of last frame held an undecodable pattern
//   frame_valid one-cycle pulse when value/dp/err_mask update
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  err_mask,
    output logic        frame_valid
);

    localparam logic [7:0] RunMax = 8'(STABLE_CYC);
    localparam logic [7:0] RunCap = 8'(STABLE_CYC - 1);

    // Returns {bad, nibble}; bad patterns decode to nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            7'h77:   res = 5'h0A;
            7'h7C:   res = 5'h0B;
            7'h39:   res = 5'h0C;
            7'h5E:   res = 5'h0D;
            7'h79:   res = 5'h0E;
            7'h71:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [7:0]       s_seg_q;
    logic [3:0]       s_an_q;
    logic [7:0]       run_q, run_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  slot_nib_q;
    logic [3:0]       slot_dp_q;
    logic [3:0]       slot_bad_q;
    logic [15:0]      value_q;
    logic [3:0]       dp_q;
    logic [3:0]       err_q;
    logic             frame_valid_q;

    logic             an_onehot;
    logic             same_pair;
    logic             capture;
    logic             frame_done;
    logic [4:0]       dec;

    // The run counter describes the pair held in s_seg_q/s_an_q, so it is
    // updated on the same edge that samples a new pair: comparing the incoming
    // bus against the registered copy is comparing consecutive samples.
    always_comb begin
        an_onehot  = (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
        same_pair  = (seg == s_seg_q) && (an == s_an_q);
        // Counter moving from STABLE_CYC-1 to STABLE_CYC; saturation makes
        // this happen once per run.
        capture    = an_onehot && same_pair && (run_q == RunCap);
        frame_done = (mask_q == 4'b1111);
        dec        = decode_seg(s_seg_q[6:0]);

        run_d = 8'd0;
        if (an_onehot) begin
            if (!same_pair) begin
                run_d = 8'd1;
            end else if (run_q == RunMax) begin
                run_d = RunMax;
            end else begin
                run_d = run_q + 8'd1;
            end
        end

        // A capture on the frame-publish edge belongs to the next frame.
        mask_d = (frame_done ? 4'b0000 : mask_q) | (capture ? s_an_q : 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg_q       <= 8'd0;
            s_an_q        <= 4'd0;
            run_q         <= 8'd0;
            mask_q        <= 4'd0;
            slot_nib_q    <= '0;
            slot_dp_q     <= 4'd0;
            slot_bad_q    <= 4'd0;
            value_q       <= 16'd0;
            dp_q          <= 4'd0;
            err_q         <= 4'd0;
            frame_valid_q <= 1'b0;
        end else begin
            s_seg_q       <= seg;
            s_an_q        <= an;
            run_q         <= run_d;
            mask_q        <= mask_d;
            frame_valid_q <= frame_done;
            if (frame_done) begin
                value_q <= slot_nib_q;
                dp_q    <= slot_dp_q;
                err_q   <= slot_bad_q;
            end
            // s_an_q is one-hot whenever capture is set.
            for (int i = 0; i < 4; i++) begin
                if (capture && s_an_q[i]) begin
                    slot_nib_q[i] <= dec[3:0];
                    slot_dp_q[i]  <= s_seg_q[7];
                    slot_bad_q[i] <= dec[4];
                end
            end
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign err_mask    = err_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  err_mask;
    logic        frame_valid;

    seg7_scan_decoder #(.STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .dp          (dp),
        .err_mask    (err_mask),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [6:0]  pats [16];
    int          m_run;
    logic [3:0]  m_prev_an;
    logic [7:0]  m_prev_seg;
    logic [3:0]  m_mask;
    int          m_nib [4];
    logic [3:0]  m_dp_s, m_bad_s;
    logic [15:0] exp_value;
    logic [3:0]  exp_dp, exp_err;
    logic        exp_fv;
    logic        prev_fv;

    typedef struct {
        logic        r;
        logic [3:0]  a;
        logic [7:0]  s;
        int          cyc;
        bit          chk;
        logic [15:0] ev;
        logic [3:0]  edp;
        logic [3:0]  eerr;
        int          epulse;
        int          pat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_prev_an = 4'd0; m_prev_seg = 8'd0; m_mask = 4'd0;
        for (int i = 0; i < 4; i++) m_nib[i] = 0;
        m_dp_s = 4'd0; m_bad_s = 4'd0;
        exp_value = 16'd0; exp_dp = 4'd0; exp_err = 4'd0; exp_fv = 1'b0;
    endtask

    // One clock edge of the specification's behaviour, given the sampled inputs.
    task automatic model_edge(input logic r, input logic [3:0] a, input logic [7:0] s);
        int old_run;
        int idx;
        int nib;
        bit bad;
        if (r) begin
            model_reset();
            return;
        end
        exp_fv = (m_mask == 4'hF);
        if (exp_fv) begin
            exp_value = 16'(m_nib[0] + 16 * m_nib[1] + 256 * m_nib[2] + 4096 * m_nib[3]);
            exp_dp    = m_dp_s;
            exp_err   = m_bad_s;
            m_mask    = 4'd0;
        end
        old_run = m_run;
        if ($countones(a) != 1) m_run = 0;
        else if (a != m_prev_an || s != m_prev_seg) m_run = 1;
        else if (m_run < S) m_run = m_run + 1;
        if ($countones(a) == 1 && m_run == S && old_run == S - 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (a[i]) idx = i;
            nib = 0;
            bad = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (pats[k] == s[6:0]) begin
                    nib = k;
                    bad = 1'b0;
                end
            end
            m_nib[idx]   = nib;
            m_dp_s[idx]  = s[7];
            m_bad_s[idx] = bad;
            m_mask[idx]  = 1'b1;
        end
        m_prev_an  = a;
        m_prev_seg = s;
    endtask

    task automatic apply(input logic r, input logic [3:0] a, input logic [7:0] s, input int n,
                         output int npulse, output int first_at);
        npulse   = 0;
        first_at = -1;
        for (int i = 0; i < n; i++) begin
            rst = r; an = a; seg = s;
            @(posedge clk);
            model_edge(r, a, s);
            #1;
            chk("cyc_value", 32'(value), 32'(exp_value));
            chk("cyc_dp", 32'(dp), 32'(exp_dp));
            chk("cyc_err", 32'(err_mask), 32'(exp_err));
            chk("cyc_fv", 32'(frame_valid), 32'(exp_fv));
            if (prev_fv === 1'b1 && frame_valid === 1'b1) begin
                errors++;
                $display("FAIL fv_back_to_back got=1 want=0 at %0t", $time);
            end
            prev_fv = frame_valid;
            if (frame_valid === 1'b1) begin
                npulse++;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    task automatic add(input logic r, input logic [3:0] a, input logic [7:0] s, input int cyc,
                       input bit c, input logic [15:0] ev, input logic [3:0] edp,
                       input logic [3:0] eerr, input int ep, input int pat);
        vec_t v;
        v.r = r; v.a = a; v.s = s; v.cyc = cyc; v.chk = c; v.ev = ev; v.edp = edp;
        v.eerr = eerr; v.epulse = ep; v.pat = pat;
        vq.push_back(v);
    endtask

    initial begin
        int np, fa, acc;
        pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        prev_fv = 1'b0;
        model_reset();
        rst = 1'b1; an = 4'd0; seg = 8'd0;

        // Reset with random bus activity
        acc = 0;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 4'($urandom), 8'($urandom), 1, np, fa);
            acc += np;
        end
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_err", 32'(err_mask), 32'h0);
        chk("rst_pulses", 32'(acc), 32'h0);

        // Nominal scan
        add(0, 4'h1, 8'h06, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h5B, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h4F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h66, 6, 1, 16'h4321, 4'h0, 4'h0, 1, S);
        // Glitch shorter than STABLE_CYC
        add(0, 4'h1, 8'h3F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h1, 8'h7F, 3, 0, 0, 0, 0, 0, -1);
        add(0, 4'h1, 8'h3F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h06, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h5B, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h4F, 6, 1, 16'h3210, 4'h0, 4'h0, 1, S);
        // Invalid pattern and decimal point
        add(0, 4'h1, 8'h3F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'hBF, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h00, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h3F, 6, 1, 16'h0000, 4'h2, 4'h4, 1, S);
        // Illegal selects
        add(0, 4'h0, 8'h7F, 10, 0, 0, 0, 0, 0, -1);
        add(0, 4'h3, 8'h7F, 10, 1, 16'h0000, 4'h2, 4'h4, 0, -1);
        // Partial frame, reset, full rescan
        add(0, 4'h1, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(1, 4'h0, 8'h00, 1, 1, 16'h0000, 4'h0, 4'h0, 0, -1);
        add(0, 4'h1, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h71, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h71, 6, 1, 16'hFFFF, 4'h0, 4'h0, 1, S);
        // Digit 3 recaptured; latest wins
        add(0, 4'h8, 8'h5B, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h66, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h1, 8'h3F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h3F, 6, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h3F, 6, 1, 16'h4000, 4'h0, 4'h0, 1, S);
        // Holds of exactly STABLE_CYC: all captured, pulse lands in next step
        add(0, 4'h1, 8'h06, S, 0, 0, 0, 0, 0, -1);
        add(0, 4'h2, 8'h5B, S, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h4F, S, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h66, S, 0, 0, 0, 0, 0, -1);
        // Holds of STABLE_CYC-1: never captured
        add(0, 4'h1, 8'h6F, S - 1, 1, 16'h4321, 4'h0, 4'h0, 1, 0);
        add(0, 4'h2, 8'h6F, S - 1, 0, 0, 0, 0, 0, -1);
        add(0, 4'h4, 8'h6F, S - 1, 0, 0, 0, 0, 0, -1);
        add(0, 4'h8, 8'h6F, S - 1, 1, 16'h4321, 4'h0, 4'h0, 0, -1);

        acc = 0;
        foreach (vq[k]) begin
            apply(vq[k].r, vq[k].a, vq[k].s, vq[k].cyc, np, fa);
            acc += np;
            if (vq[k].chk) begin
                chk($sformatf("vec%0d_value", k), 32'(value), 32'(vq[k].ev));
                chk($sformatf("vec%0d_dp", k), 32'(dp), 32'(vq[k].edp));
                chk($sformatf("vec%0d_err", k), 32'(err_mask), 32'(vq[k].eerr));
                chk($sformatf("vec%0d_pulses", k), 32'(acc), 32'(vq[k].epulse));
                if (vq[k].pat >= 0)
                    chk($sformatf("vec%0d_pulse_at", k), 32'(fa), 32'(vq[k].pat));
                acc = 0;
            end
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] a;
            logic [7:0] s;
            logic       r;
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 99) < 85) a = 4'b0001 << $urandom_range(0, 3);
            else a = 4'($urandom);
            if ($urandom_range(0, 9) < 7) s = {1'($urandom_range(0, 1)), pats[$urandom_range(0, 15)]};
            else s = 8'($urandom);
            apply(r, a, s, r ? 1 : int'($urandom_range(1, 8)), np, fa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the team's binary-to-7-segment decoder. It samples a time-multiplexed 4-digit 7-segment bus, made of segment lines plus digit-select lines. It qualifies each digit by stability, decodes segment patterns back to 4-bit hex nibbles, and assembles complete 16-bit frames. It sits between a display-driver output (or a display-bus monitor point) and logic or checkers that need the numeric value being displayed.

## Interface
Parameters:
- STABLE_CYC, 4, consecutive sampled cycles an (an, seg) pair must hold before capture; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- seg  input  8  segment pattern, active-high: seg[0]=a … seg[6]=g, seg[7]=dp.
- an  input  4  digit select, active-high, one-hot; an[i] selects digit i.
- value  output  16  last complete frame; digit i in value[4i+3:4i].
- dp  output  4  decimal-point bits of last frame; dp[i] belongs to digit i.
- err_mask  output  4  bit i=1 when digit i of last frame had an undecodable pattern.
- frame_valid  output  1  one-cycle pulse when value/dp/err_mask update.

## Operation
- Input stage: seg and an are registered every cycle (s_seg, s_an). All further logic uses the registered copies.
- Run counter (8 bits, saturating at STABLE_CYC) tracks how long the sampled pair has held:
  - set to 1 when the sampled pair differs from the previous sampled pair;
  - increments while the pair is unchanged;
  - forced to 0 while s_an is not one-hot (0000 or more than one bit set). Such samples are ignored entirely.
- Capture fires exactly once per run, when the counter equals STABLE_CYC and s_an is one-hot. Capture writes digit slot i (i = index of s_an):
  - nibble = decode(s_seg[6:0]);
  - dp bit = s_seg[7];
  - bad bit = 1 if the pattern is not in the table.
- A bad digit stores nibble 0.
- Decode table, seg[6:0] hex → nibble:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7;
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F;
  - every other pattern is bad.
- Captured mask (4 bits) gets bit i set on each capture. Recapturing a digit before frame completion overwrites that slot; the latest capture wins.
- When the mask reaches 1111, on the following edge:
  - value, dp and err_mask load from the slots;
  - frame_valid = 1 for one cycle;
  - mask clears to 0000.
  - A capture on that same edge sets its mask bit in the new frame; no capture is lost.
- Digit order is free: any scan order, or repeated digits, completes a frame once all four have been captured.
- Outputs hold between frames.

## Timing
- Reset (synchronous, one edge) sets all of the following to 0: value 0x0000, dp 0000, err_mask 0000, frame_valid 0, the input registers, the run counter, the mask and the slots.
- Reset mid-frame discards the partial frame. value keeps 0 until a full new frame completes.
- Latency: the pair is presented before edge E and sampled at E (run=1). The capture edge is E+STABLE_CYC−1. For the final digit of a frame, frame_valid is high during the cycle after edge E+STABLE_CYC.
- A pair held for fewer than STABLE_CYC sampled cycles is never captured.
- A pair held indefinitely is captured once only. The counter saturates; it does not wrap.
- Sampled pair changing on the same edge the counter would reach STABLE_CYC: no capture. The counter restarts at 1.
- Segment change with an unchanged is a new run. Likewise an change with seg unchanged.
- frame_valid is never high on two consecutive cycles.

## Test plan
- Reset: hold rst 2 cycles with random seg/an → value=0x0000, dp=0, err_mask=0, frame_valid=0; no pulse during reset.
- Nominal scan, STABLE_CYC=4: each digit held 6 cycles, order an=0001..1000, seg=06,5B,4F,66 → exactly one frame_valid pulse, value=0x4321, err_mask=0000, dp=0000. Pulse timing matches STABLE_CYC+1 edges after the last digit is first sampled.
- Glitch rejection: on digit 0, insert seg=7F for 3 cycles (shorter than STABLE_CYC) between two 6-cycle holds of seg=3F → nibble 0 captured, never 8; value[3:0]=0.
- Invalid pattern and dp: digit 2 seg=0x00, digit 1 seg=0xBF, others 3F → err_mask=0100, value=0x0000, dp=0010.
- Illegal select: an=0000 and an=0011 held 10 cycles each with seg=7F → no captures, no frame_valid.
- Reset mid-frame, then recapture: capture digits 0–2, pulse rst, then scan all four with seg=71 (F) → only one frame, value=0xFFFF. Additionally scan digit 3 twice (5B then 66) before digit 0 → value[15:12]=4.
